// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute controller for the 16-bit
// shared-bus CPU. Drives one bus enable plus latch strobes per cycle, runs the
// memory read/write handshake and resolves conditional branches from PSW Z/N.
module control_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] ir_opcode,
   input  logic [1:0] ir_cond,
   input  logic       psw_z,
   input  logic       psw_n,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       pc_latch,
   output logic       pc_inc,
   output logic       ir_latch,
   output logic       mar_latch,
   output logic       mdr_en,
   output logic       mdr_latch,
   output logic       mdr_load_mem,
   output logic       rs_en,
   output logic       rd_en,
   output logic       rd_latch,
   output logic       alu_a_latch,
   output logic       alu_en,
   output logic [2:0] alu_control,
   output logic       psw_en,
   output logic       psw_latch,
   output logic       mem_read,
   output logic       mem_write,
   output logic       halted
);

   typedef enum logic [3:0] {
      StFetch0, StFetch1, StFetch2, StDecode, StExA, StExB, StAddr, StRd,
      StLdWb, StWr0, StWr1, StBr, StMfPsw, StMtPsw, StHalt
   } state_e;

   // Pass-through ALU op; does not set flags, so the PSW holds outside EXA/EXB.
   localparam logic [2:0] AluPass = 3'b010;

   state_e state_q, state_d;
   logic   cond_true;

   // Branch condition from the flags as sampled in the BR cycle.
   always_comb begin
      cond_true = 1'b0;
      unique case (ir_cond)
         2'b00:   cond_true = 1'b1;
         2'b01:   cond_true = psw_z;
         2'b10:   cond_true = psw_n;
         default: cond_true = ~psw_z;
      endcase
   end

   // State register with synchronous reset back to FETCH0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StFetch0;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch0: state_d = StFetch1;
         StFetch1: if (mem_ready) state_d = StFetch2;
         StFetch2: state_d = StDecode;
         StDecode: begin
            if (ir_opcode <= 4'd5) begin
               state_d = StExA;
            end else begin
               unique case (ir_opcode)
                  4'd6, 4'd7: state_d = StAddr;
                  4'd8:       state_d = StBr;
                  4'd9:       state_d = StHalt;
                  4'd10:      state_d = StMfPsw;
                  4'd11:      state_d = StMtPsw;
                  default:    state_d = StFetch0;
               endcase
            end
         end
         StExA:    state_d = StExB;
         StExB:    state_d = StFetch0;
         StAddr:   state_d = (ir_opcode == 4'd6) ? StRd : StWr0;
         StRd:     if (mem_ready) state_d = StLdWb;
         StLdWb:   state_d = StFetch0;
         StWr0:    state_d = StWr1;
         StWr1:    if (mem_ready) state_d = StFetch0;
         StBr:     state_d = StFetch0;
         StMfPsw:  state_d = StFetch0;
         StMtPsw:  state_d = StFetch0;
         StHalt:   state_d = StHalt;
         default:  state_d = StFetch0;
      endcase
   end

   // Output decode from the registered state; everything forced idle while reset is high.
   always_comb begin
      pc_en        = 1'b0;
      pc_latch     = 1'b0;
      pc_inc       = 1'b0;
      ir_latch     = 1'b0;
      mar_latch    = 1'b0;
      mdr_en       = 1'b0;
      mdr_latch    = 1'b0;
      mdr_load_mem = 1'b0;
      rs_en        = 1'b0;
      rd_en        = 1'b0;
      rd_latch     = 1'b0;
      alu_a_latch  = 1'b0;
      alu_en       = 1'b0;
      alu_control  = AluPass;
      psw_en       = 1'b0;
      psw_latch    = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      halted       = 1'b0;
      if (!reset) begin
         unique case (state_q)
            StFetch0: begin
               pc_en     = 1'b1;
               mar_latch = 1'b1;
            end
            StFetch1, StRd: begin
               mem_read     = 1'b1;
               mdr_load_mem = mem_ready;
            end
            StFetch2: begin
               mdr_en   = 1'b1;
               ir_latch = 1'b1;
               pc_inc   = 1'b1;
            end
            StExA, StExB: begin
               rs_en       = (state_q == StExA);
               alu_a_latch = (state_q == StExA);
               alu_en      = (state_q == StExB);
               rd_latch    = (state_q == StExB);
               unique case (ir_opcode)
                  4'd0:    alu_control = 3'b000;
                  4'd1:    alu_control = 3'b001;
                  4'd2:    alu_control = 3'b011;
                  4'd3:    alu_control = 3'b100;
                  4'd4:    alu_control = 3'b101;
                  4'd5:    alu_control = 3'b110;
                  default: alu_control = AluPass;
               endcase
            end
            StAddr: begin
               rs_en     = 1'b1;
               mar_latch = 1'b1;
            end
            StLdWb: begin
               mdr_en   = 1'b1;
               rd_latch = 1'b1;
            end
            StWr0: begin
               rd_en     = 1'b1;
               mdr_latch = 1'b1;
            end
            StWr1: mem_write = 1'b1;
            StBr: begin
               rs_en    = cond_true;
               pc_latch = cond_true;
            end
            StMfPsw: begin
               psw_en   = 1'b1;
               rd_latch = 1'b1;
            end
            StMtPsw: begin
               rs_en     = 1'b1;
               psw_latch = 1'b1;
            end
            StHalt:   halted = 1'b1;
            default:  ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed cycle-by-cycle checks of the control sequencer
// strobes, plus a long stream of random instructions with random memory waits.
module tb_control_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] ir_opcode;
   logic [1:0] ir_cond;
   logic       psw_z, psw_n, mem_ready;
   logic       pc_en, pc_latch, pc_inc, ir_latch, mar_latch;
   logic       mdr_en, mdr_latch, mdr_load_mem;
   logic       rs_en, rd_en, rd_latch, alu_a_latch, alu_en;
   logic [2:0] alu_control;
   logic       psw_en, psw_latch, mem_read, mem_write, halted;

   int errors = 0;
   int checks = 0;

   localparam logic [17:0] PcEn       = 18'd1 << 17;
   localparam logic [17:0] PcLatch    = 18'd1 << 16;
   localparam logic [17:0] PcInc      = 18'd1 << 15;
   localparam logic [17:0] IrLatch    = 18'd1 << 14;
   localparam logic [17:0] MarLatch   = 18'd1 << 13;
   localparam logic [17:0] MdrEn      = 18'd1 << 12;
   localparam logic [17:0] MdrLatch   = 18'd1 << 11;
   localparam logic [17:0] MdrLoadMem = 18'd1 << 10;
   localparam logic [17:0] RsEn       = 18'd1 << 9;
   localparam logic [17:0] RdEn       = 18'd1 << 8;
   localparam logic [17:0] RdLatch    = 18'd1 << 7;
   localparam logic [17:0] AluALatch  = 18'd1 << 6;
   localparam logic [17:0] AluEn      = 18'd1 << 5;
   localparam logic [17:0] PswEn      = 18'd1 << 4;
   localparam logic [17:0] PswLatch   = 18'd1 << 3;
   localparam logic [17:0] MemRead    = 18'd1 << 2;
   localparam logic [17:0] MemWrite   = 18'd1 << 1;
   localparam logic [17:0] Halted     = 18'd1 << 0;
   localparam logic [2:0]  AluPass    = 3'b010;

   logic [17:0] strobes;
   logic [5:0]  bus_en;
   assign strobes = {pc_en, pc_latch, pc_inc, ir_latch, mar_latch, mdr_en, mdr_latch,
                     mdr_load_mem, rs_en, rd_en, rd_latch, alu_a_latch, alu_en, psw_en,
                     psw_latch, mem_read, mem_write, halted};
   assign bus_en  = {pc_en, mdr_en, rs_en, rd_en, alu_en, psw_en};

   control_sequencer u_dut (
      .clk          (clk),
      .reset        (reset),
      .ir_opcode    (ir_opcode),
      .ir_cond      (ir_cond),
      .psw_z        (psw_z),
      .psw_n        (psw_n),
      .mem_ready    (mem_ready),
      .pc_en        (pc_en),
      .pc_latch     (pc_latch),
      .pc_inc       (pc_inc),
      .ir_latch     (ir_latch),
      .mar_latch    (mar_latch),
      .mdr_en       (mdr_en),
      .mdr_latch    (mdr_latch),
      .mdr_load_mem (mdr_load_mem),
      .rs_en        (rs_en),
      .rd_en        (rd_en),
      .rd_latch     (rd_latch),
      .alu_a_latch  (alu_a_latch),
      .alu_en       (alu_en),
      .alu_control  (alu_control),
      .psw_en       (psw_en),
      .psw_latch    (psw_latch),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .halted       (halted)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Inputs are already set for this cycle; check mid-cycle, then advance to just past the edge.
   task automatic cyc(input string tag, input logic [17:0] exp, input logic [2:0] alu);
      #2;
      check_eq(tag, {14'd0, strobes}, {14'd0, exp});
      check_eq({tag, "_alu"}, {29'd0, alu_control}, {29'd0, alu});
      check_eq("bus_onehot0", {31'd0, $onehot0(bus_en)}, 32'd1);
      check_eq("rd_wr_excl", {31'd0, mem_read & mem_write}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] alu_code(input logic [3:0] op);
      case (op)
         4'd0:    return 3'b000;
         4'd1:    return 3'b001;
         4'd2:    return 3'b011;
         4'd3:    return 3'b100;
         4'd4:    return 3'b101;
         default: return 3'b110;
      endcase
   endfunction

   task automatic do_fetch(input int wf);
      mem_ready = 1'($urandom);
      cyc("fetch0", PcEn | MarLatch, AluPass);
      for (int i = 0; i < wf; i++) begin
         mem_ready = 1'b0;
         cyc("fetch1_wait", MemRead, AluPass);
      end
      mem_ready = 1'b1;
      cyc("fetch1_rdy", MemRead | MdrLoadMem, AluPass);
      mem_ready = 1'($urandom);
      cyc("fetch2", MdrEn | IrLatch | PcInc, AluPass);
      mem_ready = 1'($urandom);
      cyc("decode", 18'd0, AluPass);
   endtask

   // One full instruction from FETCH0; ends with the DUT back in FETCH0 (not yet checked).
   task automatic run_instr(input logic [3:0] op, input logic [1:0] cond, input logic z,
                            input logic n, input int wf, input int wm);
      logic taken;
      ir_opcode = op;
      ir_cond   = cond;
      psw_z     = z;
      psw_n     = n;
      do_fetch(wf);
      if (op <= 4'd5) begin
         mem_ready = 1'($urandom);
         cyc("exa", RsEn | AluALatch, alu_code(op));
         mem_ready = 1'($urandom);
         cyc("exb", AluEn | RdLatch, alu_code(op));
      end else begin
         case (op)
            4'd6: begin
               cyc("addr_ld", RsEn | MarLatch, AluPass);
               for (int i = 0; i < wm; i++) begin
                  mem_ready = 1'b0;
                  cyc("rd_wait", MemRead, AluPass);
               end
               mem_ready = 1'b1;
               cyc("rd_rdy", MemRead | MdrLoadMem, AluPass);
               mem_ready = 1'($urandom);
               cyc("ldwb", MdrEn | RdLatch, AluPass);
            end
            4'd7: begin
               cyc("addr_st", RsEn | MarLatch, AluPass);
               mem_ready = 1'($urandom);
               cyc("wr0", RdEn | MdrLatch, AluPass);
               for (int i = 0; i < wm; i++) begin
                  mem_ready = 1'b0;
                  cyc("wr1_wait", MemWrite, AluPass);
               end
               mem_ready = 1'b1;
               cyc("wr1_rdy", MemWrite, AluPass);
            end
            4'd8: begin
               case (cond)
                  2'b00:   taken = 1'b1;
                  2'b01:   taken = z;
                  2'b10:   taken = n;
                  default: taken = ~z;
               endcase
               mem_ready = 1'($urandom);
               cyc("br", taken ? (RsEn | PcLatch) : 18'd0, AluPass);
            end
            4'd10: cyc("mfpsw", PswEn | RdLatch, AluPass);
            4'd11: cyc("mtpsw", RsEn | PswLatch, AluPass);
            default: ;
         endcase
      end
   endtask

   initial begin
      reset     = 1'b1;
      ir_opcode = 4'd0;
      ir_cond   = 2'b00;
      psw_z     = 1'b0;
      psw_n     = 1'b0;
      mem_ready = 1'b1;

      // Reset behaviour
      @(posedge clk);
      #1;
      #2;
      check_eq("reset_strobes", {14'd0, strobes}, 32'd0);
      check_eq("reset_alu", {29'd0, alu_control}, {29'd0, AluPass});
      @(posedge clk);
      #1;
      reset = 1'b0;

      // ALU op 1, zero wait, then FETCH0 on cycle 7
      run_instr(4'd1, 2'b00, 1'b0, 1'b0, 0, 0);
      // LOAD with three RD wait cycles
      run_instr(4'd6, 2'b00, 1'b0, 1'b0, 0, 3);
      // STORE with fetch and write waits
      run_instr(4'd7, 2'b00, 1'b0, 1'b0, 1, 2);
      // Branches
      run_instr(4'd8, 2'b01, 1'b1, 1'b0, 0, 0);
      run_instr(4'd8, 2'b01, 1'b0, 1'b0, 0, 0);
      run_instr(4'd8, 2'b00, 1'b0, 1'b0, 0, 0);
      run_instr(4'd8, 2'b10, 1'b0, 1'b1, 0, 0);
      run_instr(4'd8, 2'b11, 1'b1, 1'b0, 0, 0);
      run_instr(4'd8, 2'b11, 1'b0, 1'b0, 0, 0);
      // PSW moves, NOP, remaining ALU ops
      run_instr(4'd10, 2'b00, 1'b0, 1'b0, 0, 0);
      run_instr(4'd11, 2'b00, 1'b0, 1'b0, 0, 0);
      run_instr(4'd12, 2'b00, 1'b0, 1'b0, 0, 0);
      for (int op = 0; op < 6; op++) begin
         run_instr(4'(op), 2'b00, 1'b0, 1'b0, 0, 0);
      end

      // Reset in the middle of a LOAD memory wait
      ir_opcode = 4'd6;
      do_fetch(0);
      cyc("addr_ld", RsEn | MarLatch, AluPass);
      mem_ready = 1'b0;
      cyc("rd_wait", MemRead, AluPass);
      reset = 1'b1;
      #2;
      check_eq("rst_mid_strobes", {14'd0, strobes}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // HALT holds for 20 cycles regardless of mem_ready
      ir_opcode = 4'd9;
      do_fetch(0);
      for (int i = 0; i < 20; i++) begin
         mem_ready = 1'(i & 1);
         cyc("halt", Halted, AluPass);
      end
      reset = 1'b1;
      #2;
      check_eq("halt_reset", {14'd0, strobes}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Random instruction stream; HALT replaced by a NOP so the stream keeps running
      for (int k = 0; k < 500; k++) begin
         logic [3:0] op;
         op = 4'($urandom_range(0, 15));
         if (op == 4'd9) op = 4'd12;
         run_instr(op, 2'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
      mem_ready = 1'b1;
      cyc("final_fetch0", PcEn | MarLatch, AluPass);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
